fetch_ctrl: RTL and testbench

- Pipeline control unit that sequences the instruction-fetch stage.
- Generates the IF stage's freeze, brTaken, jumpEnable and brOffset, plus flush strobes for the IF/ID and ID/EX pipeline registers.
- Resolves priority among halt, jump, taken branch, memory wait and load-use hazard; runs a small FSM for flush and stall windows.
- Keeps saturating stall and flush cycle counters for performance debug.

---
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage pipeline controller: it resolves halt, jump, branch, memory-wait and load-use priority,
// sequences the flush and stall windows, and keeps saturating debug counters.
module fetch_ctrl #(
    parameter int WORD_LEN     = 16,
    parameter int REG_ADDR     = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_src1,
    input  logic [REG_ADDR-1:0] id_src2,
    input  logic                id_two_src,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic [REG_ADDR-1:0] ex_dest,
    input  logic                branch_req,
    input  logic [WORD_LEN-1:0] branch_off,
    input  logic                jump_req,
    input  logic [WORD_LEN-1:0] jump_target,
    input  logic                mem_busy,
    input  logic                halt_req,
    output logic                freeze,
    output logic                brTaken,
    output logic                jumpEnable,
    output logic [WORD_LEN-1:0] brOffset,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                halted,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t        state_q, state_d;
    logic [2:0]    fcnt_q, fcnt_d;
    logic          pend_q, pend_d;
    logic [15:0]   stall_q, stall_d;
    logic [15:0]   flushc_q, flushc_d;

    logic                hz;
    logic                eval_run;
    logic                frz_c, bt_c, je_c, fif_c, fex_c, hlt_c;
    logic [WORD_LEN-1:0] off_c;

    // A load into r0 never creates a real dependency.
    assign hz = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                ((id_src1 == ex_dest) || (id_two_src && (id_src2 == ex_dest)));

    assign eval_run = (state_q == S_RUN) || ((state_q == S_MEM_WAIT) && !mem_busy);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        frz_c   = 1'b0;
        bt_c    = 1'b0;
        je_c    = 1'b0;
        fif_c   = 1'b0;
        fex_c   = 1'b0;
        hlt_c   = 1'b0;
        off_c   = '0;

        if (eval_run) begin
            pend_d = 1'b0;
            if (halt_req || pend_q) begin
                frz_c   = 1'b1;
                fif_c   = 1'b1;
                fex_c   = 1'b1;
                state_d = S_HALT;
            end else if (jump_req) begin
                je_c    = 1'b1;
                off_c   = jump_target;
                fcnt_d  = FLUSH_INIT;
                state_d = S_FLUSH;
            end else if (branch_req) begin
                bt_c    = 1'b1;
                off_c   = branch_off;
                fcnt_d  = FLUSH_INIT;
                state_d = S_FLUSH;
            end else if (mem_busy) begin
                frz_c   = 1'b1;
                state_d = S_MEM_WAIT;
            end else if (hz) begin
                frz_c   = 1'b1;
                fex_c   = 1'b1;
                state_d = S_RUN;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_FLUSH: begin
                    fif_c = 1'b1;
                    fex_c = 1'b1;
                    // Redirects and hazards here come from squashed instructions.
                    if (halt_req) begin
                        frz_c   = 1'b1;
                        state_d = S_HALT;
                    end else if (mem_busy) begin
                        frz_c = 1'b1;
                    end else if (fcnt_q <= 3'd1) begin
                        state_d = S_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                S_MEM_WAIT: begin
                    frz_c = 1'b1;
                    if (halt_req) begin
                        pend_d = 1'b1;
                    end
                end
                S_HALT: begin
                    frz_c = 1'b1;
                    hlt_c = 1'b1;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end

        stall_d  = (frz_c && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
        flushc_d = (fif_c && (flushc_q != 16'hFFFF)) ? flushc_q + 16'd1 : flushc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            fcnt_q   <= 3'd0;
            pend_q   <= 1'b0;
            stall_q  <= 16'd0;
            flushc_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pend_q   <= pend_d;
            stall_q  <= stall_d;
            flushc_q <= flushc_d;
        end
    end

    // Combinational outputs are forced low for as long as reset is held.
    assign freeze      = rst & frz_c;
    assign brTaken     = rst & bt_c;
    assign jumpEnable  = rst & je_c;
    assign brOffset    = rst ? off_c : '0;
    assign flush_if_id = rst & fif_c;
    assign flush_id_ex = rst & fex_c;
    assign halted      = rst & hlt_c;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flushc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle pushes a reference-model prediction,
// and a monitor compares it against the DUT on the falling edge.
module tb_fetch_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst;
    logic        id_valid, id_two_src, ex_valid, ex_mem_read;
    logic [3:0]  id_src1, id_src2, ex_dest;
    logic        branch_req, jump_req, mem_busy, halt_req;
    logic [15:0] branch_off, jump_target;
    logic        freeze, brTaken, jumpEnable, flush_if_id, flush_id_ex, halted;
    logic [15:0] brOffset, stall_cnt, flush_cnt;

    fetch_ctrl #(.WORD_LEN(16), .REG_ADDR(4), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .branch_req(branch_req), .branch_off(branch_off),
        .jump_req(jump_req), .jump_target(jump_target),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .freeze(freeze), .brTaken(brTaken), .jumpEnable(jumpEnable), .brOffset(brOffset),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic        frz, bt, je;
        logic [15:0] off;
        logic        fif, fex, hlt;
        logic [15:0] sc, fc;
    } obs_t;

    typedef struct packed {
        logic chk;
        obs_t v;
    } sb_t;

    sb_t sbq[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    // Reference model state: remaining flush cycles, waiting on memory, halted, pending halt.
    int m_left, m_stall, m_flush;
    bit m_wait, m_halt, m_pend;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic predict(input logic c);
        obs_t e;
        sb_t  s;
        bit   hz, h;
        e = '0;
        if (!rst) begin
            m_left = 0; m_wait = 0; m_halt = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        end else begin
            e.sc = 16'(m_stall);
            e.fc = 16'(m_flush);
            hz = id_valid && ex_valid && ex_mem_read && (ex_dest != 4'd0) &&
                 ((id_src1 == ex_dest) || (id_two_src && (id_src2 == ex_dest)));
            if (m_halt) begin
                e.frz = 1'b1; e.hlt = 1'b1;
            end else if (m_left > 0) begin
                e.fif = 1'b1; e.fex = 1'b1;
                if (halt_req) begin
                    e.frz = 1'b1; m_halt = 1; m_left = 0;
                end else if (mem_busy) begin
                    e.frz = 1'b1;
                end else begin
                    m_left = m_left - 1;
                end
            end else if (m_wait && mem_busy) begin
                e.frz = 1'b1;
                if (halt_req) m_pend = 1;
            end else begin
                h = halt_req || m_pend;
                m_wait = 0;
                m_pend = 0;
                if (h) begin
                    e.frz = 1'b1; e.fif = 1'b1; e.fex = 1'b1; m_halt = 1;
                end else if (jump_req) begin
                    e.je = 1'b1; e.off = jump_target; m_left = FC;
                end else if (branch_req) begin
                    e.bt = 1'b1; e.off = branch_off; m_left = FC;
                end else if (mem_busy) begin
                    e.frz = 1'b1; m_wait = 1;
                end else if (hz) begin
                    e.frz = 1'b1; e.fex = 1'b1;
                end
            end
            if (e.frz && m_stall < 65535) m_stall = m_stall + 1;
            if (e.fif && m_flush < 65535) m_flush = m_flush + 1;
        end
        s.chk = c;
        s.v   = e;
        sbq.push_back(s);
    endtask

    initial begin
        sb_t  me;
        obs_t ma;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (sbq.size() != 0) begin
                me = sbq.pop_front();
                ma = {freeze, brTaken, jumpEnable, brOffset, flush_if_id, flush_id_ex, halted,
                      stall_cnt, flush_cnt};
                if (me.chk) begin
                    n_checks = n_checks + 1;
                    if (ma !== me.v) begin
                        n_fail = n_fail + 1;
                        $display("FAIL outputs cycle=%0d act=%h exp=%h", cyc, ma, me.v);
                    end
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 1'b1;
        id_valid = 1'b0; id_two_src = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        id_src1 = 4'd0; id_src2 = 4'd0; ex_dest = 4'd0;
        branch_req = 1'b0; jump_req = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
        branch_off = 16'd0; jump_target = 16'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            predict(1'b1);
            adv();
        end
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        clr();
        #1;
        // Reset held with a branch request pending.
        rst = 1'b0;
        branch_req = 1'b1;
        predict(1'b1);
        @(negedge clk);
        chk1("rst_brTaken", brTaken, 1'b0);
        chk1("rst_freeze", freeze, 1'b0);
        chk16("rst_stall_cnt", stall_cnt, 16'd0);
        chk16("rst_flush_cnt", flush_cnt, 16'd0);
        adv();
        idle(2);
        rst = 1'b1;
        predict(1'b1);
        @(negedge clk);
        chk1("rel_brTaken", brTaken, 1'b1);
        adv();
        clr();
        idle(3);

        // Load-use hazard, then the same with r0 as destination.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 4'd3; id_valid = 1'b1; id_src1 = 4'd3;
        predict(1'b1);
        @(negedge clk);
        chk1("lu_freeze", freeze, 1'b1);
        chk1("lu_flush_id_ex", flush_id_ex, 1'b1);
        adv();
        clr();
        predict(1'b1);
        @(negedge clk);
        chk1("lu_freeze_once", freeze, 1'b0);
        chk16("lu_stall_cnt", stall_cnt, 16'd1);
        adv();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 4'd0; id_valid = 1'b1; id_src1 = 4'd0;
        predict(1'b1);
        @(negedge clk);
        chk1("lu_r0_freeze", freeze, 1'b0);
        adv();
        clr();
        idle(2);

        // Branch with a two-cycle flush window; held request is ignored.
        do_reset();
        branch_req = 1'b1; branch_off = 16'h0005;
        predict(1'b1);
        @(negedge clk);
        chk1("br_taken", brTaken, 1'b1);
        chk16("br_offset", brOffset, 16'h0005);
        adv();
        for (int i = 0; i < FC; i++) begin
            predict(1'b1);
            @(negedge clk);
            chk1("br_squash_taken", brTaken, 1'b0);
            chk1("br_flush_if_id", flush_if_id, 1'b1);
            adv();
        end
        branch_req = 1'b0;
        predict(1'b1);
        @(negedge clk);
        chk16("br_flush_cnt", flush_cnt, 16'd2);
        chk1("br_flush_done", flush_if_id, 1'b0);
        adv();

        // Jump has priority over branch.
        jump_req = 1'b1; branch_req = 1'b1; jump_target = 16'h0040; branch_off = 16'h0005;
        predict(1'b1);
        @(negedge clk);
        chk1("jb_jumpEnable", jumpEnable, 1'b1);
        chk1("jb_brTaken", brTaken, 1'b0);
        chk16("jb_brOffset", brOffset, 16'h0040);
        adv();
        clr();
        idle(3);

        // Memory wait with a halt deferred until memory is ready.
        do_reset();
        mem_busy = 1'b1;
        idle(1);
        halt_req = 1'b1;
        predict(1'b1);
        @(negedge clk);
        chk1("mw_halt_deferred", halted, 1'b0);
        adv();
        halt_req = 1'b0;
        idle(2);
        mem_busy = 1'b0;
        predict(1'b1);
        @(negedge clk);
        chk16("mw_stall_cnt", stall_cnt, 16'd4);
        adv();
        idle(2);
        predict(1'b1);
        @(negedge clk);
        chk1("mw_halted", halted, 1'b1);
        adv();
        rst = 1'b0;
        predict(1'b1);
        @(negedge clk);
        chk1("mw_reset_halted", halted, 1'b0);
        adv();
        clr();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) != 0);
            halt_req    = ($urandom_range(0, 59) == 0);
            jump_req    = ($urandom_range(0, 15) == 0);
            branch_req  = ($urandom_range(0, 7) == 0);
            mem_busy    = ($urandom_range(0, 4) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_mem_read = ($urandom_range(0, 1) == 0);
            id_two_src  = ($urandom_range(0, 1) == 0);
            id_src1     = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            ex_dest     = 4'($urandom_range(0, 3));
            branch_off  = 16'($urandom);
            jump_target = 16'($urandom);
            predict(1'b1);
            adv();
        end

        // Stall counter saturation while halted.
        do_reset();
        halt_req = 1'b1;
        idle(1);
        halt_req = 1'b0;
        for (int i = 0; i < 65600; i++) begin
            predict(1'b0);
            adv();
        end
        predict(1'b1);
        @(negedge clk);
        chk16("sat_stall_cnt", stall_cnt, 16'hFFFF);
        adv();
        rst = 1'b0;
        predict(1'b1);
        @(negedge clk);
        chk16("sat_reset_stall", stall_cnt, 16'd0);
        adv();
        clr();
        idle(2);

        repeat (3) @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (sbq.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain act=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
